im_loader: RTL and testbench

Instruction-memory loader: the write-side counterpart to the `im` read port. It accepts a big-endian byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes each word to the instruction memory's write port at consecutive word-aligned byte addresses starting at `BASE_ADDR`. It sits between the host/boot byte source and `im`, and the core is held off until `done_o`.

---
 rtl/im_pkg.sv | 11 +
 rtl/im_byte_packer.sv | 27 ++
 rtl/im_loader.sv | 92 +++++++++
 tb/tb_im_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// im_pkg: shared constants and FSM state encoding for the instruction-memory loader
package im_pkg;
   localparam int IM_WORD_BYTES = 4;
   localparam int IM_ADDR_STEP  = 4;
   localparam int IM_LEN_W      = 16;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_CSUM  = 3'd4;
endpackage

// File: rtl/im_byte_packer.sv
// im_byte_packer: shifts big-endian bytes into a 32-bit word and flags the 4th byte
module im_byte_packer
   import im_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data,
   input  logic        accept,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_full
);
   logic [1:0] cnt;
   assign word_full = accept && cnt == 2'(IM_WORD_BYTES - 1);
   // byte counter and shift register; first byte ends up in [31:24]
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt  <= '0;
         word <= '0;
      end else if (clear) begin
         cnt  <= '0;
         word <= '0;
      end else if (accept) begin
         cnt  <= cnt + 2'd1;
         word <= {word[23:0], data};
      end
endmodule

// File: rtl/im_loader.sv
// im_loader: packs a byte stream into words and writes them to instruction memory
// Optional trailing checksum word enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader
   import im_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [IM_LEN_W-1:0] len_i,
   input  logic [7:0]          byte_i,
   input  logic                byte_valid_i,
   output logic                byte_ready_o,
   output logic                we_o,
   output logic [31:0]         addr_o,
   output logic [31:0]         data_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [IM_LEN_W-1:0] count_o
);
   logic [2:0]          state;
   logic [IM_LEN_W-1:0] len_q;
   logic                accept, full, start_ok, last, csum_bad;
   logic [31:0]         word;
   assign busy_o       = state != ST_IDLE;
   assign byte_ready_o = state == ST_RECV || state == ST_CSUM;
   assign we_o         = state == ST_WRITE;
   assign done_o       = state == ST_DONE;
   assign data_o       = word;
   assign accept       = byte_valid_i && byte_ready_o;
   assign start_ok     = state == ST_IDLE && start_i && len_i != '0 && 32'(len_i) <= MAX_WORDS;
   assign last         = count_o + 1'b1 == len_q;
   im_byte_packer u_packer (
      .clk       (clk_i),
      .rst       (rst_i),
      .data      (byte_i),
      .accept    (accept),
      .clear     (start_ok),
      .word      (word),
      .word_full (full)
   );
`ifdef IM_LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_LAST = ST_CSUM;
   logic [31:0] sum;
   // running sum of every written word, compared against the trailing checksum word
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) sum <= '0;
      else if (start_ok) sum <= '0;
      else if (we_o) sum <= sum + word;
   assign csum_bad = {word[23:0], byte_i} != sum;
`else
   localparam logic [2:0] ST_LAST = ST_DONE;
   assign csum_bad = 1'b0;
`endif
   // load sequencing plus address/count/error bookkeeping
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state   <= ST_IDLE;
         len_q   <= '0;
         count_o <= '0;
         addr_o  <= BASE_ADDR;
         err_o   <= 1'b0;
      end else
         case (state)
            ST_IDLE:
               if (start_ok) begin
                  len_q   <= len_i;
                  count_o <= '0;
                  err_o   <= 1'b0;
                  addr_o  <= BASE_ADDR;
                  state   <= ST_RECV;
               end else if (start_i) begin
                  err_o <= err_o | (32'(len_i) > MAX_WORDS);
                  state <= ST_DONE;
               end
            ST_RECV: if (full) state <= ST_WRITE;
            ST_WRITE: begin
               count_o <= count_o + 1'b1;
               addr_o  <= addr_o + 32'(IM_ADDR_STEP);
               state   <= last ? ST_LAST : ST_RECV;
            end
            ST_CSUM:
               if (full) begin
                  err_o <= err_o | csum_bad;
                  state <= ST_DONE;
               end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed scoreboard bench for im_loader (optionally with IM_LOADER_CHECKSUM_EN)
module tb_im_loader;
   localparam logic [31:0] BASE = 32'h0000_0000;
   logic        clk = 0, rst = 1, start = 0, valid = 0;
   logic [15:0] len = 0;
   logic [7:0]  b = 0;
   logic        ready, we, busy, done, err;
   logic [31:0] addr, data;
   logic [15:0] count;
   int tests = 0, fails = 0, done_cnt = 0, done_cyc = 0, cyc = 0;
   logic [31:0] eaddr[$], edata[$], wds[$];

   im_loader dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .byte_i(b),
      .byte_valid_i(valid), .byte_ready_o(ready), .we_o(we), .addr_o(addr),
      .data_o(data), .busy_o(busy), .done_o(done), .err_o(err), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // cycle counter for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: every write strobe must match the next expected (addr, data)
   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (we) begin
         if (eaddr.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexp_we: got write addr %h data %h expected no write", addr, data);
         end else begin
            chk("wr_addr", addr, eaddr.pop_front());
            chk("wr_data", data, edata.pop_front());
         end
      end
   end

   task automatic push_byte(input logic [7:0] v, input bit gap);
      int k = 0;
      b = v;
      valid = 1;
      while (!ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k == 100) begin
         tests++;
         fails++;
         $error("FAIL byte_timeout: got ready=0 for 100 cycles expected ready=1");
      end
      @(negedge clk);
      if (gap) begin
         valid = 0;
         b = 8'hEE;
         @(negedge clk);
      end
   endtask

   task automatic run_load(input int n, input bit gap, input bit mid, input bit bad);
      logic [31:0] sum = 0, w;
      int dc0, t0, k = 0, extra = 0;
      bit exp_err = 0;
      for (int i = 0; i < n; i++) begin
         eaddr.push_back(BASE + 32'(4 * i));
         edata.push_back(wds[i]);
         sum += wds[i];
      end
      #1 dc0 = done_cnt;
      start = 1;
      len = 16'(n);
      @(negedge clk);
      start = 0;
      t0 = cyc;
      chk("busy_on_start", busy, 1);
      chk("ready_on_start", ready, 1);
      for (int i = 0; i < n; i++) begin
         w = wds[i];
         for (int j = 0; j < 4; j++) begin
            push_byte(w[31-8*j -: 8], gap);
            if (mid && i == 0 && j == 1) begin
               valid = 0;
               start = 1;
               len = 16'd1;
               @(negedge clk);
               start = 0;
            end
         end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      w = sum + 32'(bad);
      for (int j = 0; j < 4; j++) push_byte(w[31-8*j -: 8], gap);
      exp_err = bad;
      extra = 4;
`endif
      valid = 0;
      while (done_cnt == dc0 && k < 60) begin
         @(negedge clk);
         #1 k++;
      end
      if (!gap && !mid) chk("cycles_to_done", 32'(done_cyc - t0), 32'(5 * n + extra));
      repeat (3) @(negedge clk);
      #1;
      chk("one_done", done_cnt, dc0 + 1);
      chk("busy_after", busy, 0);
      chk("count", count, n);
      chk("err", err, exp_err);
      chk("writes_left", eaddr.size(), 0);
   endtask

   initial begin
      int dc0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, BASE);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_count", count, 0);
      rst = 0;
      // back-to-back stream
      wds = '{32'h3C01_1000, 32'h8C22_0004};
      run_load(2, 0, 0, 0);
      // stalled stream
      run_load(2, 1, 0, 0);
      // zero length
      start = 1;
      len = 0;
      @(negedge clk);
      start = 0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 1);
      @(negedge clk);
      chk("len0_done_fall", done, 0);
      chk("len0_busy_fall", busy, 0);
      chk("len0_err", err, 0);
      // over-length rejected
      start = 1;
      len = 16'd257;
      @(negedge clk);
      start = 0;
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 1);
      @(negedge clk);
      chk("rej_done_fall", done, 0);
      chk("rej_busy_fall", busy, 0);
      chk("rej_err_sticky", err, 1);
      // start pulsed mid-load is ignored; accepted start clears sticky err
      run_load(2, 0, 1, 0);
      // reset after first write of a 3-word load
      wds = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      eaddr.push_back(BASE);
      edata.push_back(32'h1111_1111);
      start = 1;
      len = 16'd3;
      @(negedge clk);
      start = 0;
      for (int j = 0; j < 4; j++) push_byte(8'h11, 0);
      push_byte(8'h22, 0);
      push_byte(8'h22, 0);
      chk("rst_mid_first_write", eaddr.size(), 0);
      dc0 = done_cnt;
      #2 rst = 1;
      valid = 0;
      #1;
      chk("arst_ready", ready, 0);
      chk("arst_we", we, 0);
      chk("arst_addr", addr, BASE);
      chk("arst_data", data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", count, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      #1 chk("arst_no_done", done_cnt, dc0);
      wds = '{32'h3C01_1000, 32'h8C22_0004};
      run_load(2, 0, 0, 0);
      // checksum words (trailing word only sent when the feature is built in)
      wds = '{32'h0000_0001, 32'h0000_0002};
      run_load(2, 0, 0, 0);
      run_load(2, 0, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
